timed_seq_ctrl: RTL and testbench
=================================

TIMED_SEQ_CTRL -- requirements
Module: timed_seq_ctrl

Interface
REQ-001 Parameters SHALL be:
- NCH, 2, request channel count (2..8).
- CW, 5, counter width.
- DWELL, 12, grant length in cycles (1..2^CW).
- GAP, 3, post-grant idle cycles (1..2^CW).
- EDGE, 1, request mode: 1 = rising-edge, 0 = level.
REQ-002 Ports SHALL be:
- CK  in  1  clock, all flops on rising edge.
- RN  in  1  reset, asynchronous, active-low.
- CLR  in  1  synchronous clear, active-high.
- REQ  in  NCH  channel requests.
- ACK  out  NCH  one-hot grant.
- CH  out  $clog2(NCH)  granted channel index.
- BUSY  out  1  state is not IDLE.
- DONE  out  1  final grant cycle.
- CNT  out  CW  phase counter.
- DROP  out  8  dropped-request count.
REQ-003 Clock and reset SHALL be exactly as stated: one clock CK; reset RN asynchronous, active-low.

Function
REQ-004 REQ SHALL be registered once into REQ_S, then delayed once more into REQ_D.
REQ-005 Edge event: REQ_S[i] & ~REQ_D[i] when EDGE=1; REQ_S[i] when EDGE=0.
REQ-006 A channel event SHALL set PEND[i] at the next CK edge.
REQ-007 If an event and a grant-clear of PEND[i] occur in the same cycle, set SHALL win.
REQ-008 With EDGE=1, an event on a channel whose PEND[i] is already 1 SHALL increment DROP, saturating at 255; it SHALL NOT increment in level mode.
REQ-009 FSM states SHALL be IDLE, GRANT and GAP.
REQ-010 IDLE -> GRANT when any PEND bit is set, with ACK and CH registered on entry.
REQ-011 GRANT -> GAP when CNT == DWELL-1.
REQ-012 GAP -> IDLE when CNT == GAP-1.
REQ-013 GAP -> GRANT directly when CNT == GAP-1 and any PEND bit is set.
REQ-014 The channel is selected round-robin: the first set PEND bit at or above pointer PTR, wrapping. On GRANT entry, PTR <= (sel+1) mod NCH and PEND[sel] clears.
REQ-015 CNT SHALL be 0 on entering any state and increment by 1 per cycle within GRANT and GAP, with no wrap beyond the limits above; CNT SHALL be 0 in IDLE.
REQ-016 ACK SHALL be one-hot during GRANT and all-zero otherwise; CH SHALL hold the last granted index.
REQ-017 DONE SHALL be combinational, high only when state == GRANT and CNT == DWELL-1.
REQ-018 Latency: REQ first sampled high at edge k -> ACK high after edge k+2, when the FSM is in IDLE.
REQ-019 CLR SHALL have priority over all other next-state logic. It SHALL force:
- FSM to IDLE;
- CNT, PEND, PTR, REQ_S, REQ_D, ACK, CH and DROP to 0.
REQ-020 CLR asserted mid-GRANT SHALL drop ACK at the next edge and SHALL NOT produce DONE.

Reset
REQ-021 RN low SHALL asynchronously force every flop to the CLR values in REQ-019.
REQ-022 Reset release SHALL take effect at the first CK edge with RN high; REQ edges seen before reset release SHALL NOT be retained.
REQ-023 Reset values SHALL be: ACK=0, CH=0, BUSY=0, DONE=0, CNT=0, DROP=0.

Structure
REQ-024 Package timed_seq_pkg SHALL hold the FSM state enum typedef and the default parameter constants.
REQ-025 Sub-module timed_seq_rr_arb SHALL be purely combinational.
- Inputs: PEND, PTR.
- Outputs: valid, selected index.
REQ-026 All remaining logic SHALL reside in timed_seq_ctrl.

Verification
REQ-027 Single request, defaults: REQ[0] pulse of 1 cycle sampled at edge 10 -> ACK=01 after edge 12 for 12 cycles; DONE high at CNT=11; BUSY low after GAP of 3 cycles.
REQ-028 Round-robin: REQ=11 both rising at the same edge -> grants on ch0 then ch1 back-to-back via GAP->GRANT; the next REQ=11 grants ch0 first again.
REQ-029 Drop: EDGE=1, REQ[1] raised 3 times while ch0 holds a grant -> one grant on ch1 and DROP=2.
REQ-030 Level mode: EDGE=0, REQ[0] held high -> continuous GRANT(12) / GAP(3) cycles; DROP stays 0.
REQ-031 CLR at CNT=5 of a GRANT -> next cycle: ACK=0, BUSY=0, CNT=0, PEND=0, DONE never asserted.
REQ-032 RN asserted mid-GAP, asynchronously between edges -> all outputs equal their reset values immediately; REQ held high across release grants only after a fresh edge (EDGE=1).

Source files
------------

// File: rtl/timed_seq_pkg.sv
// Shared types and default parameters for the timed sequence controller.
package timed_seq_pkg;

  localparam int unsigned DefNch   = 2;
  localparam int unsigned DefCw    = 5;
  localparam int unsigned DefDwell = 12;
  localparam int unsigned DefGap   = 3;
  localparam int unsigned DefEdge  = 1;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StGrant = 2'd1,
    StGap   = 2'd2
  } state_e;

endpackage

// File: rtl/timed_seq_rr_arb.sv
// Combinational round-robin pick: first set pending bit at or above the pointer, wrapping.
module timed_seq_rr_arb
  import timed_seq_pkg::*;
#(
  parameter int unsigned NCH = DefNch
) (
  input  logic [NCH-1:0]         i_pend,
  input  logic [$clog2(NCH)-1:0] i_ptr,
  output logic                   o_valid,
  output logic [$clog2(NCH)-1:0] o_sel
);

  localparam int unsigned IW = $clog2(NCH);

  int unsigned   w_pos;
  logic [IW-1:0] w_idx;

  // Scan offsets from the far end so the smallest offset from the pointer is written last.
  always_comb begin
    o_valid = 1'b0;
    o_sel   = '0;
    w_pos   = 0;
    w_idx   = '0;
    for (int k = NCH - 1; k >= 0; k--) begin
      w_pos = (32'(i_ptr) + 32'(k)) % NCH;
      w_idx = IW'(w_pos);
      if (i_pend[w_idx]) begin
        o_valid = 1'b1;
        o_sel   = w_idx;
      end
    end
  end

endmodule

// File: rtl/timed_seq_ctrl.sv
// Timed grant sequencer: request capture, round-robin arbitration, GRANT/GAP timing.
module timed_seq_ctrl
  import timed_seq_pkg::*;
#(
  parameter int unsigned NCH   = DefNch,
  parameter int unsigned CW    = DefCw,
  parameter int unsigned DWELL = DefDwell,
  parameter int unsigned GAP   = DefGap,
  parameter int unsigned EDGE  = DefEdge
) (
  input  logic                   CK,
  input  logic                   RN,
  input  logic                   CLR,
  input  logic [NCH-1:0]         REQ,
  output logic [NCH-1:0]         ACK,
  output logic [$clog2(NCH)-1:0] CH,
  output logic                   BUSY,
  output logic                   DONE,
  output logic [CW-1:0]          CNT,
  output logic [7:0]             DROP
);

  localparam int unsigned   IW        = $clog2(NCH);
  localparam logic [CW-1:0] DwellLast = CW'(DWELL - 1);
  localparam logic [CW-1:0] GapLast   = CW'(GAP - 1);
  localparam logic [IW-1:0] LastCh    = IW'(NCH - 1);

  state_e         r_state, w_state_d;
  logic [NCH-1:0] r_req_s, r_req_d, r_pend, r_ack;
  logic [NCH-1:0] w_req_s_d, w_req_d_d, w_pend_d, w_ack_d;
  logic [NCH-1:0] w_evt, w_sel_oh;
  logic [IW-1:0]  r_ptr, r_ch, w_ptr_d, w_ch_d, w_sel;
  logic [CW-1:0]  r_cnt, w_cnt_d;
  logic [7:0]     r_drop, w_drop_d;
  logic [8:0]     w_drop_sum;
  logic [3:0]     w_hits;
  logic           r_armed, w_valid, w_grant;

  assign w_evt = (EDGE != 0) ? (r_req_s & ~r_req_d) : r_req_s;

  timed_seq_rr_arb #(
    .NCH(NCH)
  ) u_arb (
    .i_pend (r_pend),
    .i_ptr  (r_ptr),
    .o_valid(w_valid),
    .o_sel  (w_sel)
  );

  // FSM state register.
  always_ff @(posedge CK or negedge RN) begin
    if (!RN) r_state <= StIdle;
    else     r_state <= w_state_d;
  end

  // FSM next state; w_grant marks a cycle that enters GRANT with a fresh selection.
  always_comb begin
    w_state_d = r_state;
    w_grant   = 1'b0;
    if (CLR) begin
      w_state_d = StIdle;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (w_valid) begin
            w_state_d = StGrant;
            w_grant   = 1'b1;
          end
        end
        StGrant: begin
          if (r_cnt == DwellLast) w_state_d = StGap;
        end
        StGap: begin
          if (r_cnt == GapLast) begin
            w_state_d = w_valid ? StGrant : StIdle;
            w_grant   = w_valid;
          end
        end
        default: w_state_d = StIdle;
      endcase
    end
  end

  // FSM outputs.
  always_comb begin
    BUSY = (r_state != StIdle);
    DONE = (r_state == StGrant) && (r_cnt == DwellLast);
  end

  // Datapath next values; CLR zeroes everything, an event beats a grant-clear of PEND.
  always_comb begin
    w_sel_oh        = '0;
    w_sel_oh[w_sel] = 1'b1;
    w_hits          = '0;
    for (int i = 0; i < NCH; i++) w_hits = w_hits + 4'(w_evt[i] & r_pend[i]);
    w_drop_sum = {1'b0, r_drop} + 9'(w_hits);

    w_req_s_d = '0;
    w_req_d_d = '0;
    w_pend_d  = '0;
    w_ack_d   = '0;
    w_ptr_d   = '0;
    w_ch_d    = '0;
    w_cnt_d   = '0;
    w_drop_d  = '0;
    if (!CLR) begin
      w_req_s_d = REQ;
      // Until the first edge after reset, seed the delay stage so a held level is not an edge.
      w_req_d_d = r_armed ? r_req_s : REQ;
      w_pend_d  = (r_pend & ~(w_grant ? w_sel_oh : '0)) | w_evt;
      w_ptr_d   = w_grant ? ((w_sel == LastCh) ? '0 : w_sel + 1'b1) : r_ptr;
      w_ch_d    = w_grant ? w_sel : r_ch;
      w_ack_d   = w_grant ? w_sel_oh : ((w_state_d == StGrant) ? r_ack : '0);
      w_cnt_d   = ((w_state_d != r_state) || (r_state == StIdle)) ? '0 : r_cnt + 1'b1;
      if (EDGE != 0) w_drop_d = (w_drop_sum > 9'd255) ? 8'hff : w_drop_sum[7:0];
      else           w_drop_d = r_drop;
    end
  end

  // Datapath registers.
  always_ff @(posedge CK or negedge RN) begin
    if (!RN) begin
      r_req_s <= '0;
      r_req_d <= '0;
      r_armed <= 1'b0;
      r_pend  <= '0;
      r_ack   <= '0;
      r_ptr   <= '0;
      r_ch    <= '0;
      r_cnt   <= '0;
      r_drop  <= '0;
    end else begin
      r_req_s <= w_req_s_d;
      r_req_d <= w_req_d_d;
      r_armed <= 1'b1;
      r_pend  <= w_pend_d;
      r_ack   <= w_ack_d;
      r_ptr   <= w_ptr_d;
      r_ch    <= w_ch_d;
      r_cnt   <= w_cnt_d;
      r_drop  <= w_drop_d;
    end
  end

  assign ACK  = r_ack;
  assign CH   = r_ch;
  assign CNT  = r_cnt;
  assign DROP = r_drop;

endmodule

// File: tb/tb_timed_seq_ctrl.sv
// Bench for timed_seq_ctrl: edge-mode and level-mode instances, grant scoreboard.
module tb_timed_seq_ctrl;

  localparam int unsigned DWELL = 12;

  logic       ck = 1'b0;
  logic       rn = 1'b1;
  logic       clr = 1'b0;
  logic [1:0] req_e = '0, req_l = '0;
  logic [1:0] ack_e, ack_l;
  logic [0:0] ch_e, ch_l;
  logic       busy_e, busy_l, done_e, done_l;
  logic [4:0] cnt_e, cnt_l;
  logic [7:0] drop_e, drop_l;

  int n_cmp = 0;
  int n_bad = 0;
  int q_exp[$];
  logic [1:0] prev_ack = '0;
  int glen = 0, done_at = 0, exp_len = DWELL;

  always #5 ck = ~ck;

  timed_seq_ctrl #(.NCH(2), .CW(5), .DWELL(12), .GAP(3), .EDGE(1)) u_dut_e (
    .CK(ck), .RN(rn), .CLR(clr), .REQ(req_e), .ACK(ack_e), .CH(ch_e),
    .BUSY(busy_e), .DONE(done_e), .CNT(cnt_e), .DROP(drop_e)
  );

  timed_seq_ctrl #(.NCH(2), .CW(5), .DWELL(12), .GAP(3), .EDGE(0)) u_dut_l (
    .CK(ck), .RN(rn), .CLR(clr), .REQ(req_l), .ACK(ack_l), .CH(ch_l),
    .BUSY(busy_l), .DONE(done_l), .CNT(cnt_l), .DROP(drop_l)
  );

  // Advance one cycle, sample 1 time unit after the edge and run the grant scoreboard.
  task automatic tick();
    int e;
    logic [1:0] ea;
    @(posedge ck);
    #1;
    if (ack_e !== 2'b00 && prev_ack === 2'b00) begin
      n_cmp++;
      if (q_exp.size() == 0) begin
        n_bad++;
        $display("FAIL grant_unexpected: ack=%b ch=%0d, required no grant", ack_e, ch_e);
      end else begin
        e  = q_exp.pop_front();
        ea = 2'(1 << e);
        if (ack_e !== ea || ch_e !== 1'(e)) begin
          n_bad++;
          $display("FAIL grant_channel: ack=%b ch=%0d, required ack=%b ch=%0d", ack_e, ch_e, ea, e);
        end
      end
      glen    = 1;
      done_at = done_e ? 1 : 0;
    end else if (ack_e !== 2'b00) begin
      glen++;
      if (done_e) done_at = glen;
    end else if (prev_ack !== 2'b00) begin
      n_cmp++;
      if (glen != exp_len || done_at != ((exp_len == DWELL) ? DWELL : 0)) begin
        n_bad++;
        $display("FAIL grant_length: len=%0d done_at=%0d, required len=%0d done_at=%0d",
                 glen, done_at, exp_len, (exp_len == DWELL) ? DWELL : 0);
      end
    end
    prev_ack = ack_e;
  endtask

  task automatic test_reset();
    #2 rn = 1'b0;
    repeat (3) @(posedge ck);
    #1;
    n_cmp++;
    if (ack_e !== 2'b00 || ch_e !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_ack_ch: ack=%b ch=%0d, required ack=00 ch=0", ack_e, ch_e);
    end
    n_cmp++;
    if (busy_e !== 1'b0 || done_e !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_busy_done: busy=%b done=%b, required 0 0", busy_e, done_e);
    end
    n_cmp++;
    if (cnt_e !== 5'd0 || drop_e !== 8'd0) begin
      n_bad++;
      $display("FAIL reset_cnt_drop: cnt=%0d drop=%0d, required 0 0", cnt_e, drop_e);
    end
    rn = 1'b1;
    repeat (2) tick();
    n_cmp++;
    if (busy_e !== 1'b0 || busy_l !== 1'b0 || ack_l !== 2'b00) begin
      n_bad++;
      $display("FAIL reset_release_idle: busy_e=%b busy_l=%b ack_l=%b, required 0 0 00",
               busy_e, busy_l, ack_l);
    end
  endtask

  task automatic test_round_robin();
    int t, t0, t1;
    for (int r = 0; r < 2; r++) begin
      tick();
      req_e = 2'b11;
      q_exp.push_back(0);
      q_exp.push_back(1);
      tick();
      req_e = 2'b00;
      t = 0; t0 = -1; t1 = -1;
      while ((q_exp.size() != 0 || busy_e === 1'b1) && t < 80) begin
        tick();
        t++;
        if (ack_e === 2'b01 && t0 < 0) t0 = t;
        if (ack_e === 2'b10 && t1 < 0) t1 = t;
      end
      n_cmp++;
      if (q_exp.size() != 0 || busy_e !== 1'b0) begin
        n_bad++;
        $display("FAIL rr_drain: pending=%0d busy=%b, required 0 0", q_exp.size(), busy_e);
        q_exp.delete();
      end
      n_cmp++;
      if (t0 < 0 || t1 - t0 != 15) begin
        n_bad++;
        $display("FAIL rr_back_to_back: ch0 at %0d ch1 at %0d, required ch1 15 after ch0", t0, t1);
      end
    end
    n_cmp++;
    if (ch_e !== 1'b1) begin
      n_bad++;
      $display("FAIL rr_ch_hold: ch=%0d, required 1", ch_e);
    end
  endtask

  task automatic test_single();
    int t;
    tick();
    req_e = 2'b01;
    q_exp.push_back(0);
    tick();
    req_e = 2'b00;
    tick();
    n_cmp++;
    if (ack_e !== 2'b00 || busy_e !== 1'b0) begin
      n_bad++;
      $display("FAIL single_early: ack=%b busy=%b, required 00 0", ack_e, busy_e);
    end
    tick();
    n_cmp++;
    if (ack_e !== 2'b01 || busy_e !== 1'b1 || cnt_e !== 5'd0) begin
      n_bad++;
      $display("FAIL single_latency: ack=%b busy=%b cnt=%0d, required 01 1 0", ack_e, busy_e, cnt_e);
    end
    t = 1;
    while (busy_e === 1'b1 && t < 40) begin
      tick();
      if (busy_e === 1'b1) t++;
    end
    n_cmp++;
    if (t != 15) begin
      n_bad++;
      $display("FAIL single_busy_len: busy cycles=%0d, required 15", t);
    end
  endtask

  task automatic test_drop();
    int t;
    tick();
    req_e = 2'b01;
    q_exp.push_back(0);
    tick();
    req_e = 2'b00;
    t = 0;
    while (ack_e !== 2'b01 && t < 10) begin
      tick();
      t++;
    end
    n_cmp++;
    if (ack_e !== 2'b01) begin
      n_bad++;
      $display("FAIL drop_first_grant: ack=%b, required 01", ack_e);
    end
    q_exp.push_back(1);
    repeat (3) begin
      req_e = 2'b10;
      tick();
      req_e = 2'b00;
      tick();
    end
    t = 0;
    while ((q_exp.size() != 0 || busy_e === 1'b1) && t < 60) begin
      tick();
      t++;
    end
    n_cmp++;
    if (q_exp.size() != 0 || busy_e !== 1'b0) begin
      n_bad++;
      $display("FAIL drop_drain: pending=%0d busy=%b, required 0 0", q_exp.size(), busy_e);
      q_exp.delete();
    end
    n_cmp++;
    if (drop_e !== 8'd2) begin
      n_bad++;
      $display("FAIL drop_count: drop=%0d, required 2", drop_e);
    end
    repeat (5) tick();
  endtask

  task automatic test_level();
    int t, ph;
    logic [1:0] ea;
    req_l = 2'b01;
    t = 0;
    while (ack_l === 2'b00 && t < 10) begin
      tick();
      t++;
    end
    n_cmp++;
    if (ack_l !== 2'b01) begin
      n_bad++;
      $display("FAIL level_start: ack=%b, required 01", ack_l);
    end
    for (int i = 0; i < 45; i++) begin
      ph = i % 15;
      ea = (ph < 12) ? 2'b01 : 2'b00;
      n_cmp++;
      if (ack_l !== ea || cnt_l !== 5'((ph < 12) ? ph : ph - 12) || done_l !== (ph == 11)) begin
        n_bad++;
        $display("FAIL level_cycle%0d: ack=%b cnt=%0d done=%b, required ack=%b cnt=%0d done=%b",
                 i, ack_l, cnt_l, done_l, ea, (ph < 12) ? ph : ph - 12, ph == 11);
      end
      tick();
    end
    n_cmp++;
    if (drop_l !== 8'd0 || ch_l !== 1'b0) begin
      n_bad++;
      $display("FAIL level_drop: drop=%0d ch=%0d, required 0 0", drop_l, ch_l);
    end
    req_l = 2'b00;
    clr   = 1'b1;
    tick();
    clr   = 1'b0;
    n_cmp++;
    if (ack_l !== 2'b00 || busy_l !== 1'b0 || cnt_l !== 5'd0 || drop_e !== 8'd0) begin
      n_bad++;
      $display("FAIL clr_idle: ack_l=%b busy_l=%b cnt_l=%0d drop_e=%0d, required 00 0 0 0",
               ack_l, busy_l, cnt_l, drop_e);
    end
    repeat (5) tick();
    n_cmp++;
    if (ack_l !== 2'b00 || busy_l !== 1'b0) begin
      n_bad++;
      $display("FAIL clr_no_regrant: ack=%b busy=%b, required 00 0", ack_l, busy_l);
    end
  endtask

  task automatic test_clr_mid_grant();
    int t;
    logic seen;
    exp_len = 6;
    tick();
    req_e = 2'b01;
    q_exp.push_back(0);
    tick();
    req_e = 2'b00;
    t = 0;
    while (ack_e === 2'b00 && t < 10) begin
      tick();
      t++;
    end
    req_e = 2'b10;
    tick();
    req_e = 2'b00;
    t = 0;
    while (cnt_e !== 5'd5 && t < 12) begin
      tick();
      t++;
    end
    n_cmp++;
    if (ack_e !== 2'b01 || cnt_e !== 5'd5) begin
      n_bad++;
      $display("FAIL clr_setup: ack=%b cnt=%0d, required 01 5", ack_e, cnt_e);
    end
    clr = 1'b1;
    tick();
    clr = 1'b0;
    n_cmp++;
    if (ack_e !== 2'b00 || busy_e !== 1'b0 || cnt_e !== 5'd0 || done_e !== 1'b0) begin
      n_bad++;
      $display("FAIL clr_mid_grant: ack=%b busy=%b cnt=%0d done=%b, required 00 0 0 0",
               ack_e, busy_e, cnt_e, done_e);
    end
    seen = 1'b0;
    repeat (20) begin
      tick();
      seen = seen | (ack_e !== 2'b00) | done_e;
    end
    n_cmp++;
    if (seen !== 1'b0) begin
      n_bad++;
      $display("FAIL clr_pend_cleared: activity=%b, required 0", seen);
    end
    exp_len = DWELL;
  endtask

  task automatic test_reset_mid_gap();
    int t;
    logic seen;
    tick();
    req_e = 2'b10;
    q_exp.push_back(1);
    tick();
    req_e = 2'b00;
    t = 0;
    while (ack_e === 2'b00 && t < 10) begin
      tick();
      t++;
    end
    t = 0;
    while (ack_e !== 2'b00 && t < 20) begin
      tick();
      t++;
    end
    tick();
    n_cmp++;
    if (busy_e !== 1'b1 || cnt_e !== 5'd1 || ch_e !== 1'b1) begin
      n_bad++;
      $display("FAIL gap_setup: busy=%b cnt=%0d ch=%0d, required 1 1 1", busy_e, cnt_e, ch_e);
    end
    #3 rn = 1'b0;
    #1;
    n_cmp++;
    if (ack_e !== 2'b00 || ch_e !== 1'b0 || busy_e !== 1'b0 || done_e !== 1'b0 ||
        cnt_e !== 5'd0 || drop_e !== 8'd0) begin
      n_bad++;
      $display("FAIL async_reset: ack=%b ch=%0d busy=%b done=%b cnt=%0d drop=%0d, required all 0",
               ack_e, ch_e, busy_e, done_e, cnt_e, drop_e);
    end
    req_e = 2'b01;
    @(posedge ck);
    @(posedge ck);
    #3 rn = 1'b1;
    seen = 1'b0;
    repeat (10) begin
      tick();
      seen = seen | (ack_e !== 2'b00) | busy_e;
    end
    n_cmp++;
    if (seen !== 1'b0) begin
      n_bad++;
      $display("FAIL held_req_no_grant: activity=%b, required 0", seen);
    end
    req_e = 2'b00;
    tick();
    tick();
    req_e = 2'b01;
    q_exp.push_back(0);
    tick();
    tick();
    req_e = 2'b00;
    t = 0;
    while ((q_exp.size() != 0 || busy_e === 1'b1) && t < 40) begin
      tick();
      t++;
    end
    n_cmp++;
    if (q_exp.size() != 0 || busy_e !== 1'b0) begin
      n_bad++;
      $display("FAIL fresh_edge_grant: pending=%0d busy=%b, required 0 0", q_exp.size(), busy_e);
      q_exp.delete();
    end
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_single();
    test_drop();
    test_level();
    test_clr_mid_grant();
    test_reset_mid_gap();
    n_cmp++;
    if (q_exp.size() != 0) begin
      n_bad++;
      $display("FAIL leftover_expected: pending=%0d, required 0", q_exp.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
